turret_cmd_sequencer: RTL and testbench
=======================================

Name: turret_cmd_sequencer

Overview:
- Command scheduler in front of angle_decoder.
- Arbitrates the manual (joystick/button) and auto (tracking) requesters for the x/y axis codes.
- Sequences the fire servo through a timed fire → recoil → cooldown cycle and freezes aim during the shot.
- Outputs are registered 4-bit codes that drive angle_decoder's x_angle, y_angle and fire_angle inputs; its a_xangle and a_yangle inputs are tied to 0.

Parameters:
- FIRE_CYCLES, 4, clock cycles fire_cmd holds 1 (fire).
- RECOIL_CYCLES, 3, clock cycles fire_cmd holds 2 (recoil).
- COOLDOWN_CYCLES, 2, clock cycles fire_cmd holds 0 while busy stays high.
- MAN_TIMEOUT, 5, consecutive idle manual cycles before auto may take ownership.
- CNT_W, 32, width of the internal timers; every cycle parameter must be below 2^CNT_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- man_x  input  4  manual x code (0 none, 1 left, 2 right, 5 released).
- man_y  input  4  manual y code (0 none, 1 up, 2 down, 5 released).
- man_fire  input  1  manual fire button, level.
- auto_en  input  1  auto mode enable switch.
- auto_x  input  4  auto x code, same encoding as man_x.
- auto_y  input  4  auto y code, same encoding as man_y.
- auto_fire  input  1  auto fire request, level.
- x_cmd  output  4  registered x code to the decoder.
- y_cmd  output  4  registered y code to the decoder.
- fire_cmd  output  4  registered fire code (0 idle, 1 fire, 2 recoil).
- owner  output  1  0 = manual, 1 = auto.
- busy  output  1  high while a shot sequence is active.
- shot_count  output  8  accepted shots, wraps 255 → 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on reset. All state changes on the rising edge of clk.
- Reset values: x_cmd = 0, y_cmd = 0, fire_cmd = 0, owner = 0, busy = 0, shot_count = 0. Fire FSM goes to IDLE, idle counter to 0, edge-detect registers to 0.
- Reset mid-shot aborts the sequence; fire_cmd = 0 on the next cycle.
- Code validation: an input code other than 0, 1, 2 or 5 is treated as 0.
- "Manual active" means man_x != 0 or man_y != 0 after validation.
- Ownership FSM, state OWN_MAN:
  - The idle counter clears when manual is active and increments otherwise, saturating at MAN_TIMEOUT.
  - Transition to OWN_AUTO when auto_en = 1 and the counter has reached MAN_TIMEOUT.
- Ownership FSM, state OWN_AUTO:
  - Transition to OWN_MAN on the next edge if manual is active, man_fire rises, or auto_en = 0.
  - The idle counter clears on that transition.
  - Manual preemption wins over every other condition in the same cycle.
- owner reflects the FSM state.
- Axis path, one cycle latency: x_cmd/y_cmd take the current owner's validated codes, sampled with the owner value in effect this cycle.
  - Forced to 0 while the fire FSM is in FIRE or RECOIL.
  - Not forced during COOLDOWN.
- Fire request sources:
  - The rising edge of man_fire is always a request.
  - The rising edge of auto_fire is a request only when owner = 1.
  - Edges use registered previous values, so an input held high produces exactly one request.
- Fire FSM, IDLE → FIRE → RECOIL → COOLDOWN → IDLE:
  - A request in IDLE at cycle n is accepted. From cycle n+1, fire_cmd = 1 for FIRE_CYCLES cycles, then 2 for RECOIL_CYCLES cycles, then 0 for COOLDOWN_CYCLES cycles.
  - busy is high from n+1 through the last cooldown cycle, then low.
  - shot_count increments at n+1.
  - Requests outside IDLE are dropped, not queued.
  - Simultaneous manual and auto requests count as one shot.
  - A zero COOLDOWN_CYCLES skips COOLDOWN and returns RECOIL → IDLE directly.

Test Plan:
- Reset: assert reset for 2 cycles while man_x = 1 and man_fire = 1 → all outputs 0 during and 1 cycle after reset; no shot until man_fire falls and rises again.
- Manual path: man_x = 1, man_y = 2 → x_cmd = 1, y_cmd = 2 one cycle later with owner = 0. Input man_x = 7 → x_cmd = 0.
- Takeover and preemption: auto_en = 1, manual idle, auto_x = 2 → owner = 1 after 5 idle cycles, then x_cmd = 2. Pulse man_y = 1 → owner = 0 on the next edge and y_cmd = 1 the following cycle.
- Shot timing: man_fire rises at cycle n → fire_cmd = 1 for cycles n+1..n+4, 2 for n+5..n+7, 0 with busy = 1 for n+8..n+9, busy = 0 at n+10. shot_count 0 → 1; x_cmd/y_cmd = 0 during n+1..n+7 while man_x = 1 is held.
- Drop and gating: a second man_fire edge at n+3 leaves shot_count at 1. An auto_fire edge while owner = 0 produces no shot. Simultaneous man_fire and auto_fire edges with owner = 1 produce exactly one shot.
- Wrap and abort: fire 256 shots → shot_count reads 0. Assert reset during RECOIL → fire_cmd = 0 and busy = 0 on the next cycle.

Source files
------------

// File: rtl/turret_cmd_sequencer.sv
// turret_cmd_sequencer: arbitrates manual/auto aim requesters and runs the
// timed fire -> recoil -> cooldown sequence feeding angle_decoder.
module turret_cmd_sequencer #(
  parameter int unsigned FIRE_CYCLES     = 4,
  parameter int unsigned RECOIL_CYCLES   = 3,
  parameter int unsigned COOLDOWN_CYCLES = 2,
  parameter int unsigned MAN_TIMEOUT     = 5,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] man_x,
  input  logic [3:0] man_y,
  input  logic       man_fire,
  input  logic       auto_en,
  input  logic [3:0] auto_x,
  input  logic [3:0] auto_y,
  input  logic       auto_fire,
  output logic [3:0] x_cmd,
  output logic [3:0] y_cmd,
  output logic [3:0] fire_cmd,
  output logic       owner,
  output logic       busy,
  output logic [7:0] shot_count
);

  typedef enum logic {OWN_MAN, OWN_AUTO} own_state_t;
  typedef enum logic [1:0] {F_IDLE, F_FIRE, F_RECOIL, F_COOLDOWN} fire_state_t;

  localparam logic [CNT_W-1:0] MAN_TO      = CNT_W'(MAN_TIMEOUT);
  localparam logic [CNT_W-1:0] FIRE_LAST   = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOIL_LAST = CNT_W'(RECOIL_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Unknown direction codes collapse to "none".
  function automatic logic [3:0] validate(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd5: validate = code;
      default:                validate = '0;
    endcase
  endfunction

  own_state_t       own_state;
  fire_state_t      f_state;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] f_cnt;
  logic [3:0]       mx_v, my_v, ax_v, ay_v;
  logic             man_active;
  logic             man_fire_q, auto_fire_q, armed;
  logic             man_rise, auto_rise, fire_req;
  logic             aim_freeze_next;

  assign mx_v       = validate(man_x);
  assign my_v       = validate(man_y);
  assign ax_v       = validate(auto_x);
  assign ay_v       = validate(auto_y);
  assign man_active = (mx_v != '0) || (my_v != '0);
  assign owner      = (own_state == OWN_AUTO);

  // armed masks the first post-reset cycle so a button held through reset
  // is not seen as a fresh edge; the edge registers themselves reset to 0.
  assign man_rise  = armed & man_fire & ~man_fire_q;
  assign auto_rise = armed & auto_fire & ~auto_fire_q & owner;
  assign fire_req  = man_rise | auto_rise;

  // Edge-detect history for the fire inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      man_fire_q  <= 1'b0;
      auto_fire_q <= 1'b0;
      armed       <= 1'b0;
    end else begin
      man_fire_q  <= man_fire;
      auto_fire_q <= auto_fire;
      armed       <= 1'b1;
    end
  end

  // Ownership FSM with manual idle timeout and manual preemption.
  always_ff @(posedge clk) begin
    if (reset) begin
      own_state <= OWN_MAN;
      idle_cnt  <= '0;
    end else begin
      case (own_state)
        OWN_MAN: begin
          if (man_active)
            idle_cnt <= '0;
          else if (idle_cnt < MAN_TO)
            idle_cnt <= idle_cnt + CNT_ONE;
          if (auto_en && (idle_cnt == MAN_TO))
            own_state <= OWN_AUTO;
        end
        OWN_AUTO: begin
          if (man_active || man_rise || !auto_en) begin
            own_state <= OWN_MAN;
            idle_cnt  <= '0;
          end
        end
        default: own_state <= OWN_MAN;
      endcase
    end
  end

  // Aim is frozen whenever the fire FSM will be in FIRE or RECOIL next cycle.
  always_comb begin
    aim_freeze_next = 1'b0;
    case (f_state)
      F_IDLE:   aim_freeze_next = fire_req;
      F_FIRE:   aim_freeze_next = 1'b1;
      F_RECOIL: aim_freeze_next = (f_cnt != RECOIL_LAST);
      default:  aim_freeze_next = 1'b0;
    endcase
  end

  // Registered axis codes from the current owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_cmd <= '0;
      y_cmd <= '0;
    end else if (aim_freeze_next) begin
      x_cmd <= '0;
      y_cmd <= '0;
    end else begin
      x_cmd <= owner ? ax_v : mx_v;
      y_cmd <= owner ? ay_v : my_v;
    end
  end

  // Fire sequencer with registered fire_cmd/busy/shot_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_state    <= F_IDLE;
      f_cnt      <= '0;
      fire_cmd   <= '0;
      busy       <= 1'b0;
      shot_count <= '0;
    end else begin
      case (f_state)
        F_IDLE: begin
          if (fire_req) begin
            f_state    <= F_FIRE;
            f_cnt      <= '0;
            fire_cmd   <= 4'd1;
            busy       <= 1'b1;
            shot_count <= shot_count + 8'd1;
          end
        end
        F_FIRE: begin
          if (f_cnt == FIRE_LAST) begin
            f_state  <= F_RECOIL;
            f_cnt    <= '0;
            fire_cmd <= 4'd2;
          end else begin
            f_cnt <= f_cnt + CNT_ONE;
          end
        end
        F_RECOIL: begin
          if (f_cnt == RECOIL_LAST) begin
            f_cnt    <= '0;
            fire_cmd <= '0;
            if (COOLDOWN_CYCLES == 0) begin
              f_state <= F_IDLE;
              busy    <= 1'b0;
            end else begin
              f_state <= F_COOLDOWN;
            end
          end else begin
            f_cnt <= f_cnt + CNT_ONE;
          end
        end
        F_COOLDOWN: begin
          if (f_cnt == COOL_LAST) begin
            f_state <= F_IDLE;
            f_cnt   <= '0;
            busy    <= 1'b0;
          end else begin
            f_cnt <= f_cnt + CNT_ONE;
          end
        end
        default: f_state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turret_cmd_sequencer.sv
// Directed bench for turret_cmd_sequencer: vector table for reset, manual
// path and takeover; hand sequences for shot timing, gating, wrap and abort.
module tb_turret_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] man_x, man_y, auto_x, auto_y;
  logic       man_fire, auto_en, auto_fire;
  logic [3:0] x_cmd, y_cmd, fire_cmd;
  logic       owner, busy;
  logic [7:0] shot_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  turret_cmd_sequencer #(
    .FIRE_CYCLES(4),
    .RECOIL_CYCLES(3),
    .COOLDOWN_CYCLES(2),
    .MAN_TIMEOUT(5),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .man_x(man_x),
    .man_y(man_y),
    .man_fire(man_fire),
    .auto_en(auto_en),
    .auto_x(auto_x),
    .auto_y(auto_y),
    .auto_fire(auto_fire),
    .x_cmd(x_cmd),
    .y_cmd(y_cmd),
    .fire_cmd(fire_cmd),
    .owner(owner),
    .busy(busy),
    .shot_count(shot_count)
  );

  typedef struct {
    logic       rst;
    logic [3:0] mx, my;
    logic       mf, ae;
    logic [3:0] ax, ay;
    logic       af;
    logic [3:0] ex, ey, ef;
    logic       eo, eb;
    logic [7:0] es;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] ex, input logic [3:0] ey,
                         input logic [3:0] ef, input logic eo, input logic eb,
                         input logic [7:0] es);
    chk({nm, ".x_cmd"},      32'(x_cmd),      32'(ex));
    chk({nm, ".y_cmd"},      32'(y_cmd),      32'(ey));
    chk({nm, ".fire_cmd"},   32'(fire_cmd),   32'(ef));
    chk({nm, ".owner"},      32'(owner),      32'(eo));
    chk({nm, ".busy"},       32'(busy),       32'(eb));
    chk({nm, ".shot_count"}, 32'(shot_count), 32'(es));
  endtask

  task automatic one_shot();
    man_fire = 1'b1;
    tick();
    man_fire = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    //           rst   mx     my     mf    ae    ax     ay     af     ex     ey     ef    eo    eb    es
    vecs[0]  = '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 4'd7, 4'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 4'd0, 4'd1, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{1'b0, 4'd0, 4'd1, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[15] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
    vecs[16] = '{1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};

    reset = 1'b1; man_x = '0; man_y = '0; man_fire = 1'b0;
    auto_en = 1'b0; auto_x = '0; auto_y = '0; auto_fire = 1'b0;

    // Table: reset with held inputs, manual path, takeover, preemption.
    for (int i = 0; i < 17; i++) begin
      reset = vecs[i].rst;  man_x = vecs[i].mx;  man_y = vecs[i].my;
      man_fire = vecs[i].mf; auto_en = vecs[i].ae; auto_x = vecs[i].ax;
      auto_y = vecs[i].ay;  auto_fire = vecs[i].af;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ef,
              vecs[i].eo, vecs[i].eb, vecs[i].es);
    end

    // Shot timing with man_x = 1 held; second edge at n+3 is dropped.
    man_fire = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all($sformatf("shot_n+%0d", k),
              (k <= 7) ? 4'd0 : 4'd1, 4'd0,
              (k <= 4) ? 4'd1 : ((k <= 7) ? 4'd2 : 4'd0),
              1'b0, (k <= 9), 8'd1);
      if (k == 2) man_fire = 1'b0;
      if (k == 3) man_fire = 1'b1;
    end
    man_fire = 1'b0;
    tick();

    // auto_fire edge while manual owns: no shot.
    auto_fire = 1'b1;
    tick(); tick();
    chk("auto_gated.shot_count", 32'(shot_count), 32'd1);
    chk("auto_gated.busy", 32'(busy), 32'd0);
    auto_fire = 1'b0;
    tick();

    // Auto takeover again after the manual idle timeout.
    man_x = '0; auto_en = 1'b1; auto_x = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("takeover%0d.owner", i), 32'(owner), (i == 6) ? 32'd1 : 32'd0);
    end

    // Simultaneous manual and auto edges: one shot, manual preempts.
    man_fire = 1'b1; auto_fire = 1'b1;
    tick();
    chk_all("simul", 4'd0, 4'd0, 4'd1, 1'b0, 1'b1, 8'd2);
    man_fire = 1'b0; auto_fire = 1'b0; auto_en = 1'b0;
    repeat (10) tick();
    chk("simul_end.shot_count", 32'(shot_count), 32'd2);
    chk("simul_end.busy", 32'(busy), 32'd0);

    // Counter wrap: 253 more shots to 255, one more to 0.
    for (int s = 0; s < 253; s++) one_shot();
    chk("wrap255.shot_count", 32'(shot_count), 32'd255);
    one_shot();
    chk("wrap0.shot_count", 32'(shot_count), 32'd0);

    // Reset during RECOIL aborts the shot.
    man_fire = 1'b1;
    tick();
    man_fire = 1'b0;
    repeat (4) tick();
    chk("abort_pre.fire_cmd", 32'(fire_cmd), 32'd2);
    chk("abort_pre.busy", 32'(busy), 32'd1);
    chk("abort_pre.shot_count", 32'(shot_count), 32'd1);
    reset = 1'b1;
    tick();
    chk_all("abort", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
